// File: rtl/axi_sram_pkg.sv
// Shared types, response/burst codes and address helpers for the AXI SRAM slave.
package axi_sram_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WWAIT, BRESP} state_t;

   // Captured AR/AW request; addr advances per beat.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
      logic [LEN_W-1:0]  len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } req_t;

   // True when addr falls in [base, base + limit).
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W:0]   limit);
      logic [ADDR_W:0] off;
      off = {1'b0, addr - base};
      return (addr >= base) && (off < limit);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [1:0]        burst,
                                                   input logic [2:0]        size);
      return (burst == BURST_FIXED) ? addr : addr + (ADDR_W'(1) << size);
   endfunction
endpackage

// File: rtl/axi_sram_mem.sv
// DEPTH x 64 storage with byte-strobed write port and asynchronous read port; no reset.
module axi_sram_mem
   import axi_sram_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/axi_sram.sv
// AXI4 slave SRAM: one outstanding read or write burst at a time, fixed R/B latency.
module axi_sram
   import axi_sram_pkg::*;
#(
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned WR_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        awready,
   input  logic        awvalid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   output logic        wready,
   input  logic        wvalid,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   output logic        arready,
   input  logic        arvalid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 3;

   state_t             state, state_d;
   req_t               req_q, req_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx, rd_idx;
   logic [DATA_W-1:0]  rd_data;

   logic               rd_ok, rvalid_d, rlast_d, bvalid_d;
   logic [1:0]         rresp_d, bresp_d;
   logic [DATA_W-1:0]  rdata_d;

   axi_sram_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wdata),
      .wr_strb (wstrb),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // Writes target the current beat; reads look up the beat about to be presented.
   assign wr_idx = IDX_W'((req_q.addr - BASE) >> 3);
   assign rd_idx = IDX_W'((req_d.addr - BASE) >> 3);

   // Next-state and request/beat bookkeeping.
   always_comb begin
      state_d = state;
      req_d   = req_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      case (state)
         IDLE: begin
            if (arvalid && arready) begin
               req_d   = '{addr: araddr, id: arid, len: arlen, size: arsize, burst: arburst};
               beat_d  = '0;
               cnt_d   = CNT_W'(RD_LAT);
               state_d = RWAIT;
            end else if (awvalid && awready) begin
               req_d   = '{addr: awaddr, id: awid, len: awlen, size: awsize, burst: awburst};
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = WDATA;
            end
         end
         RWAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = RDATA;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RDATA: begin
            if (rvalid && rready) begin
               if (beat_q == req_q.len) begin
                  state_d = IDLE;
               end else begin
                  beat_d     = beat_q + LEN_W'(1);
                  req_d.addr = next_addr(req_q.addr, req_q.burst, req_q.size);
               end
            end
         end
         WDATA: begin
            if (wvalid && wready) begin
               wr_en = addr_ok(req_q.addr, BASE, LIMIT);
               err_d = err_q || !wr_en;
               if ((beat_q == req_q.len) || wlast) begin
                  cnt_d   = CNT_W'(WR_LAT);
                  state_d = WWAIT;
               end else begin
                  beat_d     = beat_q + LEN_W'(1);
                  req_d.addr = next_addr(req_q.addr, req_q.burst, req_q.size);
               end
            end
         end
         WWAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = BRESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BRESP: begin
            if (bvalid && bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered R/B outputs.
   always_comb begin
      rd_ok    = addr_ok(req_d.addr, BASE, LIMIT);
      rvalid_d = (state_d == RDATA);
      rlast_d  = rvalid_d && (beat_d == req_d.len);
      rresp_d  = (rvalid_d && !rd_ok) ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = (rvalid_d && rd_ok) ? rd_data : '0;
      bvalid_d = (state_d == BRESP);
      bresp_d  = (bvalid_d && err_d) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         req_q   <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         arready <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         rlast   <= 1'b0;
         rid     <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
         bid     <= '0;
      end else begin
         state   <= state_d;
         req_q   <= req_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         arready <= (state_d == IDLE);
         awready <= (state_d == IDLE);
         wready  <= (state_d == WDATA);
         rvalid  <= rvalid_d;
         rdata   <= rdata_d;
         rresp   <= rresp_d;
         rlast   <= rlast_d;
         rid     <= req_d.id;
         bvalid  <= bvalid_d;
         bresp   <= bresp_d;
         bid     <= req_d.id;
      end
   end
endmodule

// File: tb/tb_axi_sram.sv
// Randomized bench for axi_sram against an array-based memory model of the bus rules.
module tb_axi_sram;
   import axi_sram_pkg::*;

   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam int unsigned DEPTH   = 64;
   localparam int unsigned RD_LAT  = 2;
   localparam int unsigned WR_LAT  = 2;
   localparam int          TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        awready, awvalid;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wready, wvalid, wlast;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arready, arvalid;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready, rlast;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;

   axi_sram #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
      .clk(clk), .rst(rst),
      .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid)
   );

   always #5 clk = ~clk;

   logic [63:0] model [DEPTH];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'(8 * DEPTH));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 3);
   endfunction

   function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] burst,
                                        input logic [2:0] size);
      if (burst == 2'b00) return a;
      return a + (32'd1 << size);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] s);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // rmode: 0 rready always high, 1 toggles 1,0,1,0..., 2 random. abort_beat >= 0 pulses rst there.
   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int rmode, input int abort_beat);
      logic [31:0] a;
      logic [63:0] exp_d;
      logic [1:0]  exp_r;
      int k, n, cyc, stall;
      araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
      k = 0;
      while (!arready && k < TIMEOUT) begin tick(); k++; end
      check("ar_accept", 64'(arready), 64'd1);
      if (!arready) begin arvalid = 1'b0; return; end
      tick();
      arvalid = 1'b0;
      k = 0;
      while (!rvalid && k < TIMEOUT) begin tick(); k++; end
      check("rd_latency", 64'(k), 64'(RD_LAT));
      if (!rvalid) return;
      a = addr;
      n = int'(len);
      cyc = 0;
      for (int b = 0; b <= n; b++) begin
         if (b == abort_beat) begin
            rst = 1'b1; rready = 1'b0;
            tick();
            rst = 1'b0;
            check("rst_rvalid", 64'(rvalid), 64'd0);
            check("rst_arready", 64'(arready), 64'd0);
            tick();
            check("rst_arready_rel", 64'(arready), 64'd1);
            check("rst_rvalid_rel", 64'(rvalid), 64'd0);
            return;
         end
         exp_d = in_range(a) ? model[widx(a)] : 64'd0;
         exp_r = in_range(a) ? RESP_OKAY : RESP_SLVERR;
         stall = 0;
         forever begin
            check("rvalid", 64'(rvalid), 64'd1);
            check("rdata", rdata, exp_d);
            check("rresp", 64'(rresp), 64'(exp_r));
            check("rlast", 64'(rlast), 64'(b == n));
            check("rid", 64'(rid), 64'(id));
            case (rmode)
               0:       rready = 1'b1;
               1:       rready = (cyc % 2 == 0);
               default: rready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            tick();
            cyc++;
            if (rready) break;
            stall++;
            if (stall > TIMEOUT) return;
         end
         rready = 1'b0;
         a = step(a, burst, size);
      end
      check("r_end_rvalid", 64'(rvalid), 64'd0);
      check("r_end_arready", 64'(arready), 64'd1);
   endtask

   // last_at: beat index carrying wlast (len for a full burst, less for an early wlast).
   task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at,
                           input logic [63:0] d0, input logic [7:0] s0);
      logic [31:0] a;
      logic        err;
      int k;
      awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
      wdata = d0; wstrb = s0; wlast = (last_at == 0); wvalid = 1'b1;
      check("w_stall_pre_aw", 64'(wready), 64'd0);
      k = 0;
      while (!awready && k < TIMEOUT) begin tick(); k++; end
      check("aw_accept", 64'(awready), 64'd1);
      if (!awready) begin awvalid = 1'b0; wvalid = 1'b0; return; end
      tick();
      awvalid = 1'b0;
      a = addr;
      err = 1'b0;
      for (int b = 0; b <= last_at; b++) begin
         if (b > 0) begin
            wdata = {$urandom, $urandom};
            wstrb = 8'($urandom);
            wlast = (b == last_at);
            if ($urandom_range(0, 3) == 0) begin
               wvalid = 1'b0;
               tick();
               check("wready_gap", 64'(wready), 64'd1);
               wvalid = 1'b1;
            end
         end
         k = 0;
         while (!wready && k < TIMEOUT) begin tick(); k++; end
         check("wready", 64'(wready), 64'd1);
         if (!wready) begin wvalid = 1'b0; return; end
         tick();
         if (in_range(a)) model[widx(a)] = merge(model[widx(a)], wdata, wstrb);
         else err = 1'b1;
         a = step(a, burst, size);
      end
      wvalid = 1'b0;
      wlast = 1'b0;
      check("wready_after_last", 64'(wready), 64'd0);
      k = 0;
      while (!bvalid && k < TIMEOUT) begin tick(); k++; end
      check("b_latency", 64'(k), 64'(WR_LAT));
      check("bresp", 64'(bresp), 64'(err ? RESP_SLVERR : RESP_OKAY));
      check("bid", 64'(bid), 64'(id));
      repeat ($urandom_range(0, 2)) begin
         tick();
         check("b_hold", 64'(bvalid), 64'd1);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("b_done", 64'(bvalid), 64'd0);
      check("b_awready", 64'(awready), 64'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      int          w, last_at;
      logic [31:0] ra;
      logic [7:0]  rlen;
      logic [1:0]  rburst;
      logic [2:0]  rsize;

      rst = 1'b1;
      awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
      wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
      arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
      rready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         model[i] = {$urandom, $urandom};
         dut.u_mem.mem[i] = model[i];
      end
      model[0] = 64'h1111_2222_3333_4444;
      dut.u_mem.mem[0] = model[0];

      repeat (3) tick();
      check("rst_arready", 64'(arready), 64'd0);
      check("rst_awready", 64'(awready), 64'd0);
      check("rst_wready", 64'(wready), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_bvalid", 64'(bvalid), 64'd0);
      check("rst_rlast", 64'(rlast), 64'd0);
      check("rst_rresp", 64'(rresp), 64'd0);
      check("rst_bresp", 64'(bresp), 64'd0);
      rst = 1'b0;
      check("rel_arready_same", 64'(arready), 64'd0);
      tick();
      check("rel_arready", 64'(arready), 64'd1);
      check("rel_awready", 64'(awready), 64'd1);

      // single-beat read of the preloaded word 0
      do_read(BASE, 4'h5, 8'd0, BURST_INCR, 3'd3, 0, -1);
      // 4-beat INCR read with rready 1,0,1,0
      do_read(BASE, 4'h3, 8'd3, BURST_INCR, 3'd3, 1, -1);
      // low-half strobe write, then read it back
      do_write(BASE + 32'd8, 4'h7, 8'd0, BURST_INCR, 3'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      do_read(BASE + 32'd8, 4'h7, 8'd0, BURST_INCR, 3'd3, 0, -1);

      // simultaneous AR and AW: read wins, write follows
      awaddr = BASE + 32'd16; awid = 4'h9; awlen = 8'd1; awburst = BURST_INCR; awsize = 3'd3;
      awvalid = 1'b1;
      do_read(BASE + 32'd16, 4'h2, 8'd1, BURST_INCR, 3'd3, 0, -1);
      check("both_no_b", 64'(bvalid), 64'd0);
      do_write(BASE + 32'd16, 4'h9, 8'd1, BURST_INCR, 3'd3, 1, {$urandom, $urandom}, 8'hFF);
      do_read(BASE + 32'd16, 4'h2, 8'd1, BURST_INCR, 3'd3, 2, -1);

      // out-of-range read and write, then confirm no aliasing into low or high words
      do_read(BASE + 32'(8 * DEPTH), 4'h1, 8'd0, BURST_INCR, 3'd3, 0, -1);
      do_write(BASE + 32'(8 * DEPTH), 4'h4, 8'd0, BURST_INCR, 3'd3, 0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
      do_read(BASE, 4'h1, 8'd0, BURST_INCR, 3'd3, 0, -1);
      do_read(BASE + 32'(8 * (DEPTH - 1)), 4'h1, 8'd1, BURST_INCR, 3'd3, 0, -1);

      // reset during beat 2 of a 4-beat read, then a clean read
      do_read(BASE, 4'hA, 8'd3, BURST_INCR, 3'd3, 0, 1);
      do_read(BASE + 32'd24, 4'hB, 8'd2, BURST_INCR, 3'd3, 1, -1);

      for (int it = 0; it < 60; it++) begin
         w      = int'($urandom_range(0, DEPTH + 3));
         ra     = BASE + 32'(8 * w) - 32'd16 + 32'($urandom_range(0, 7));
         rlen   = 8'($urandom_range(0, 7));
         rburst = ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR;
         rsize  = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            do_read(ra, 4'($urandom), rlen, rburst, rsize, 2, -1);
         end else begin
            last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rlen))) : int'(rlen);
            do_write(ra, 4'($urandom), rlen, rburst, rsize, last_at,
                     {$urandom, $urandom}, 8'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
